// File: rtl/uctl_lbuf_ctrl.sv
// Local-buffer controller: register-array storage behind a write port (mem0)
// and a read port (mem1), each with a req/ack FSM and programmable wait states.
module uctl_lbuf_ctrl #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT_CYC   = 0
) (
    input  logic                 coreClk,
    input  logic                 coreRst,
    input  logic [ADDR_SIZE-1:0] mem0_addr,
    input  logic [DATA_SIZE-1:0] mem0_dataIn,
    input  logic                 mem0_wr,
    output logic                 mem0_ackOut,
    input  logic [ADDR_SIZE-1:0] mem1_addr,
    input  logic                 mem1_rd,
    output logic                 mem1_ackOut,
    output logic [DATA_SIZE-1:0] mem1_dataOut,
    output logic                 mem1_dataVld,
    output logic                 lbuf_errAddr,
    input  logic                 lbuf_errClr
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] WLOAD = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    logic [DATA_SIZE-1:0]  mem [DEPTH];

    state_t                w_state, w_next;
    logic [3:0]            w_cnt;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic [DATA_SIZE-1:0]  w_data;

    state_t                r_state, r_next;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic                  r_oor;

    logic                  w_take, r_take;
    logic                  w_in_oor, r_in_oor;
    logic                  bypass;
    logic                  err_set, err_q;

    // Byte-lane bits carry no meaning for full-word accesses.
    logic unused_ok;
    assign unused_ok = ^{mem0_addr[1:0], mem1_addr[1:0]};

    assign w_take   = (w_state == S_IDLE) && mem0_wr;
    assign r_take   = (r_state == S_IDLE) && mem1_rd;
    assign w_in_oor = |mem0_addr[ADDR_SIZE-1:DEPTH_LOG2+2];
    assign r_in_oor = |mem1_addr[ADDR_SIZE-1:DEPTH_LOG2+2];

    // Write-port state register and wait counter.
    always_ff @(posedge coreClk) begin
        if (coreRst) begin
            w_state <= S_IDLE;
            w_cnt   <= '0;
        end else begin
            w_state <= w_next;
            if (w_state == S_WAIT) w_cnt <= w_cnt - 4'd1;
            else if (w_take)       w_cnt <= WLOAD;
        end
    end

    // Write-port next state: IDLE -> WAIT (skipped when no wait) -> ACK.
    always_comb begin
        w_next = w_state;
        case (w_state)
            S_IDLE: if (mem0_wr) w_next = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
            S_WAIT: if (w_cnt <= 4'd1) w_next = S_ACK;
            S_ACK:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Read-port state register and wait counter.
    always_ff @(posedge coreClk) begin
        if (coreRst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= r_next;
            if (r_state == S_WAIT) r_cnt <= r_cnt - 4'd1;
            else if (r_take)       r_cnt <= WLOAD;
        end
    end

    // Read-port next state, same shape as the write port.
    always_comb begin
        r_next = r_state;
        case (r_state)
            S_IDLE: if (mem1_rd) r_next = (WAIT_CYC == 0) ? S_ACK : S_WAIT;
            S_WAIT: if (r_cnt <= 4'd1) r_next = S_ACK;
            S_ACK:  r_next = S_IDLE;
            default: r_next = S_IDLE;
        endcase
    end

    // Capture request fields so a request dropped early still completes.
    always_ff @(posedge coreClk) begin
        if (w_take) begin
            w_idx  <= mem0_addr[DEPTH_LOG2+1:2];
            w_oor  <= w_in_oor;
            w_data <= mem0_dataIn;
        end
        if (r_take) begin
            r_idx <= mem1_addr[DEPTH_LOG2+1:2];
            r_oor <= r_in_oor;
        end
    end

    // Commit the latched write at the end of its ack cycle.
    always_ff @(posedge coreClk) begin
        if (w_state == S_ACK && !w_oor) mem[w_idx] <= w_data;
    end

    assign mem0_ackOut  = (w_state == S_ACK);
    assign mem1_ackOut  = (r_state == S_ACK);
    assign mem1_dataVld = (r_state == S_ACK);
    assign bypass       = mem0_ackOut && !w_oor && (w_idx == r_idx);

    // Read data with write-first bypass; zero outside the valid pulse.
    always_comb begin
        mem1_dataOut = '0;
        if (mem1_dataVld && !r_oor)
            mem1_dataOut = bypass ? w_data : mem[r_idx];
    end

    assign err_set = (mem0_ackOut && w_oor) || (mem1_ackOut && r_oor);

    // Sticky range error; a new error outranks a clear in the same cycle.
    always_ff @(posedge coreClk) begin
        if (coreRst)          err_q <= 1'b0;
        else if (err_set)     err_q <= 1'b1;
        else if (lbuf_errClr) err_q <= 1'b0;
    end

    assign lbuf_errAddr = err_q || err_set;

endmodule

// File: tb/tb_uctl_lbuf_ctrl.sv
// Directed bench for uctl_lbuf_ctrl: three instances (WAIT_CYC 0, 2, 3)
// with a read-data scoreboard checked whenever a data-valid pulse appears.
module tb_uctl_lbuf_ctrl;

    localparam int WT [3] = '{0, 2, 3};

    typedef struct {
        int          inst;
        logic [31:0] d;
    } exp_t;

    logic        clk;
    logic        rst  [3];
    logic [31:0] a0   [3];
    logic [31:0] d0   [3];
    logic        wr   [3];
    logic        ack0 [3];
    logic [31:0] a1   [3];
    logic        rd   [3];
    logic        ack1 [3];
    logic [31:0] dout [3];
    logic        vld  [3];
    logic        err  [3];
    logic        clr  [3];

    exp_t sb [$];
    exp_t mon_e;
    int   errs   = 0;
    int   checks = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        uctl_lbuf_ctrl #(.WAIT_CYC(WT[g])) u_dut (
            .coreClk     (clk),
            .coreRst     (rst[g]),
            .mem0_addr   (a0[g]),
            .mem0_dataIn (d0[g]),
            .mem0_wr     (wr[g]),
            .mem0_ackOut (ack0[g]),
            .mem1_addr   (a1[g]),
            .mem1_rd     (rd[g]),
            .mem1_ackOut (ack1[g]),
            .mem1_dataOut(dout[g]),
            .mem1_dataVld(vld[g]),
            .lbuf_errAddr(err[g]),
            .lbuf_errClr (clr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_wr(input int i, input logic [31:0] a,
                         input logic [31:0] d, input int lat);
        int n;
        a0[i] = a;
        d0[i] = d;
        wr[i] = 1'b1;
        tick();
        n = 1;
        while (!ack0[i] && n < 20) begin
            tick();
            n++;
        end
        wr[i] = 1'b0;
        chk("wr_lat", n, lat);
        tick();
    endtask

    task automatic do_rd(input int i, input logic [31:0] a,
                         input logic [31:0] e, input int lat);
        int n;
        sb.push_back('{inst: i, d: e});
        a1[i] = a;
        rd[i] = 1'b1;
        tick();
        n = 1;
        while (!ack1[i] && n < 20) begin
            tick();
            n++;
        end
        rd[i] = 1'b0;
        chk("rd_lat", n, lat);
        tick();
    endtask

    // Scoreboard: every valid read pops the oldest expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i]) begin
                if (sb.size() == 0) begin
                    chk("unexp_vld", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd_inst", i, mon_e.inst);
                    chk("rd_data", dout[i], mon_e.d);
                    chk("vld_ack", {31'd0, ack1[i]}, 32'd1);
                end
            end
        end
    end

    initial begin
        int seen;
        int k;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            a0[i] = '0;
            d0[i] = '0;
            wr[i] = 1'b0;
            a1[i] = '0;
            rd[i] = 1'b0;
            clr[i] = 1'b0;
        end
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_ack0", {31'd0, ack0[i]}, 32'd0);
            chk("rst_ack1", {31'd0, ack1[i]}, 32'd0);
            chk("rst_vld", {31'd0, vld[i]}, 32'd0);
            chk("rst_err", {31'd0, err[i]}, 32'd0);
            chk("rst_dout", dout[i], 32'd0);
            rst[i] = 1'b0;
        end
        tick();

        // Basic write then read, no wait states.
        do_wr(0, 32'h10, 32'hDEADBEEF, 1);
        tick();
        do_rd(0, 32'h10, 32'hDEADBEEF, 1);
        chk("dout_idle", dout[0], 32'd0);

        // Same-cycle write and read of one word returns the new data.
        do_wr(0, 32'h20, 32'h11111111, 1);
        a0[0] = 32'h20;
        d0[0] = 32'h22222222;
        wr[0] = 1'b1;
        a1[0] = 32'h20;
        rd[0] = 1'b1;
        sb.push_back('{inst: 0, d: 32'h22222222});
        tick();
        chk("byp_ack0", {31'd0, ack0[0]}, 32'd1);
        chk("byp_ack1", {31'd0, ack1[0]}, 32'd1);
        wr[0] = 1'b0;
        rd[0] = 1'b0;
        tick();
        do_rd(0, 32'h20, 32'h22222222, 1);

        // Out-of-range write and read.
        do_wr(0, 32'h0, 32'h12345678, 1);
        a0[0] = 32'h400;
        d0[0] = 32'hFFFFFFFF;
        wr[0] = 1'b1;
        tick();
        chk("oor_ack", {31'd0, ack0[0]}, 32'd1);
        chk("oor_err_rise", {31'd0, err[0]}, 32'd1);
        wr[0] = 1'b0;
        tick();
        chk("oor_err_sticky", {31'd0, err[0]}, 32'd1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("oor_err_clr", {31'd0, err[0]}, 32'd0);
        do_rd(0, 32'h0, 32'h12345678, 1);
        do_rd(0, 32'h400, 32'h0, 1);
        chk("oor_rd_err", {31'd0, err[0]}, 32'd1);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        chk("oor_rd_clr", {31'd0, err[0]}, 32'd0);

        // Reset in the middle of a waiting write drops it.
        do_wr(1, 32'h8, 32'hAA, 3);
        a0[1] = 32'h8;
        d0[1] = 32'h55;
        wr[1] = 1'b1;
        tick();
        chk("mid_noack", {31'd0, ack0[1]}, 32'd0);
        rst[1] = 1'b1;
        wr[1] = 1'b0;
        tick();
        rst[1] = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            if (ack0[1]) seen++;
            tick();
        end
        chk("rst_noack", seen, 0);
        do_rd(1, 32'h8, 32'hAA, 3);

        // Three wait states: held read acks every fifth cycle.
        do_wr(2, 32'h44, 32'h3C3C3C3C, 4);
        for (int n = 0; n < 3; n++)
            sb.push_back('{inst: 2, d: 32'h3C3C3C3C});
        a1[2] = 32'h44;
        rd[2] = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            chk("hold_ack", {31'd0, ack1[2]},
                {31'd0, (n % 5) == 4});
        end
        rd[2] = 1'b0;
        tick();
        tick();

        // Concurrent streaming writes and reads on separate words.
        do_wr(0, 32'h40, 32'hCAFEF00D, 1);
        for (int n = 0; n < 16; n++)
            sb.push_back('{inst: 0, d: 32'hCAFEF00D});
        k = 0;
        a0[0] = 32'h0;
        d0[0] = 32'hA0000000;
        wr[0] = 1'b1;
        a1[0] = 32'h40;
        rd[0] = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            tick();
            chk("ind_ack0", {31'd0, ack0[0]}, {31'd0, n[0]});
            chk("ind_ack1", {31'd0, ack1[0]}, {31'd0, n[0]});
            if (ack0[0]) begin
                k++;
                a0[0] = 32'(k * 4);
                d0[0] = 32'hA0000000 | 32'(k);
            end
        end
        wr[0] = 1'b0;
        rd[0] = 1'b0;
        tick();
        for (int j = 0; j < 16; j++)
            do_rd(0, 32'(j * 4), 32'hA0000000 | 32'(j), 1);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
